// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Package    : ahb_pkg
// Purpose    : Shared AHB encodings: transfer types, response codes and the
//              default-slave state encoding used by interconnect blocks.
// Revision   : 1.0 - initial release
// ============================================================================
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_t;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_OK   = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  // NONSEQ and SEQ are the only transfer types that demand a response;
  // both have bit 1 set.
  function automatic logic is_active_trans(input logic [1:0] t);
    return t[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_default_slave.sv
`default_nettype none
// ============================================================================
// Module     : ahb_default_slave
// Purpose    : AHB default slave. Answers unmapped transfers with the
//              two-cycle ERROR response (wait+ERROR, then ready+ERROR).
// Ports      : clk   - clock, all state on posedge
//              reset - synchronous, active-high
//              start - an unmapped NONSEQ/SEQ is being captured this cycle
//              ready - HREADY contribution of the default slave (registered)
//              resp  - HRESP contribution of the default slave (registered)
// Revision   : 1.0 - initial release
// ============================================================================
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic ready,
  output logic resp
);

  ds_state_t state_q;
  logic      ready_q;
  logic      resp_q;

  // Outputs are registered alongside the state so each state's response is
  // presented for the whole cycle that state is current.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DS_OK;
      ready_q <= 1'b1;
      resp_q  <= RESP_OKAY;
    end else begin
      case (state_q)
        DS_OK: begin
          if (start) begin
            state_q <= DS_ERR1;
            ready_q <= 1'b0;
            resp_q  <= RESP_ERROR;
          end
        end
        DS_ERR1: begin
          state_q <= DS_ERR2;
          ready_q <= 1'b1;
          resp_q  <= RESP_ERROR;
        end
        DS_ERR2: begin
          // The bus is ready in ERR2, so a new address phase is accepted
          // here; another unmapped active transfer chains straight into ERR1.
          if (start) begin
            state_q <= DS_ERR1;
            ready_q <= 1'b0;
            resp_q  <= RESP_ERROR;
          end else begin
            state_q <= DS_OK;
            ready_q <= 1'b1;
            resp_q  <= RESP_OKAY;
          end
        end
        default: begin
          state_q <= DS_OK;
          ready_q <= 1'b1;
          resp_q  <= RESP_OKAY;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign resp  = resp_q;

endmodule
`default_nettype wire

// File: rtl/ahb_resp_mux.sv
`default_nettype none
// ============================================================================
// Module     : ahb_resp_mux
// Purpose    : N-peripheral AHB read-data/response multiplexor with a built-in
//              default slave for unmapped or ambiguous selects.
// Ports      : clk, reset            - clock / synchronous active-high reset
//              sel[PrphCount]        - one-hot address-phase select
//              trans[2]              - HTRANS of the current address phase
//              prphRData             - packed per-peripheral read data
//              prphReadyOut          - per-peripheral readyOut
//              prphResp              - per-peripheral resp
//              rData, ready, resp    - muxed data-phase signals to manager
// Revision   : 1.0 - initial release
// ============================================================================
module ahb_resp_mux
  import ahb_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int PrphCount = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [PrphCount-1:0]           sel,
  input  logic [1:0]                     trans,
  input  logic [PrphCount*DataWidth-1:0] prphRData,
  input  logic [PrphCount-1:0]           prphReadyOut,
  input  logic [PrphCount-1:0]           prphResp,
  output logic [DataWidth-1:0]           rData,
  output logic                           ready,
  output logic                           resp
);

  localparam int IdxW  = (PrphCount > 1) ? $clog2(PrphCount) : 1;
  localparam int Slots = 1 << IdxW;

  // Data-phase select register: index plus valid (valid=0 means default).
  logic [IdxW-1:0] idx_q, idx_d;
  logic            valid_q, valid_d;

  // One-hot to index encoder.
  logic [IdxW-1:0] enc_idx;
  logic            enc_seen;
  logic            enc_multi;
  logic            enc_onehot;

  always_comb begin
    enc_idx   = '0;
    enc_seen  = 1'b0;
    enc_multi = 1'b0;
    for (int i = 0; i < PrphCount; i++) begin
      if (sel[i]) begin
        if (enc_seen) enc_multi = 1'b1;
        enc_seen = 1'b1;
        enc_idx  = IdxW'(i);
      end
    end
    enc_onehot = enc_seen & ~enc_multi;
  end

  // Capture only while the bus is ready; wait states hold the data phase.
  always_comb begin
    idx_d   = idx_q;
    valid_d = valid_q;
    if (ready) begin
      idx_d   = enc_idx;
      valid_d = enc_onehot;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  // Default slave starts its ERROR sequence when an unmapped active transfer
  // is captured.
  logic ds_start;
  logic ds_ready;
  logic ds_resp;

  assign ds_start = ready & ~enc_onehot & is_active_trans(trans);

  ahb_default_slave u_default_slave (
    .clk   (clk),
    .reset (reset),
    .start (ds_start),
    .ready (ds_ready),
    .resp  (ds_resp)
  );

  // Peripheral inputs padded out to a power-of-two table so the registered
  // index can address it directly for any PrphCount.
  logic [DataWidth-1:0] rdata_arr [Slots];
  logic [Slots-1:0]     ready_arr;
  logic [Slots-1:0]     resp_arr;

  for (genvar g = 0; g < Slots; g++) begin : g_slot
    if (g < PrphCount) begin : g_used
      assign rdata_arr[g] = prphRData[g*DataWidth +: DataWidth];
      assign ready_arr[g] = prphReadyOut[g];
      assign resp_arr[g]  = prphResp[g];
    end else begin : g_pad
      assign rdata_arr[g] = '0;
      assign ready_arr[g] = 1'b1;
      assign resp_arr[g]  = RESP_OKAY;
    end
  end

  // An out-of-range index is treated as the default target.
  logic idx_inrange;
  if (Slots == PrphCount) begin : g_full
    assign idx_inrange = 1'b1;
  end else begin : g_part
    assign idx_inrange = ({1'b0, idx_q} < (IdxW+1)'(PrphCount));
  end

  logic tgt_prph;
  assign tgt_prph = valid_q & idx_inrange;

  always_comb begin
    rData = '0;
    ready = ds_ready;
    resp  = ds_resp;
    if (tgt_prph) begin
      rData = rdata_arr[idx_q];
      ready = ready_arr[idx_q];
      resp  = resp_arr[idx_q];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_resp_mux.sv
`default_nettype none
// ============================================================================
// Module     : tb_ahb_resp_mux
// Purpose    : Self-checking bench for ahb_resp_mux: directed scenarios with
//              literal expectations plus randomized traffic checked against a
//              transaction-level reference model.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_ahb_resp_mux;

  localparam int DW = 32;
  localparam int PC = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [PC-1:0]     sel;
  logic [1:0]        trans;
  logic [PC*DW-1:0]  prphRData;
  logic [PC-1:0]     prphReadyOut;
  logic [PC-1:0]     prphResp;
  logic [DW-1:0]     rData;
  logic              ready;
  logic              resp;

  ahb_resp_mux #(.DataWidth(DW), .PrphCount(PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .sel          (sel),
    .trans        (trans),
    .prphRData    (prphRData),
    .prphReadyOut (prphReadyOut),
    .prphResp     (prphResp),
    .rData        (rData),
    .ready        (ready),
    .resp         (resp)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model: which peripheral owns the data phase (-1 = default
  // slave) and how many ERROR cycles remain for an unmapped transfer.
  int m_tgt   = -1;
  int m_err   = 0;
  bit armed   = 0;

  logic [DW-1:0] e_data;
  logic          e_ready;
  logic          e_resp;

  task automatic model_expect();
    if (m_tgt >= 0) begin
      e_data  = prphRData[m_tgt*DW +: DW];
      e_ready = prphReadyOut[m_tgt];
      e_resp  = prphResp[m_tgt];
    end else begin
      e_data  = '0;
      e_ready = (m_err != 2);   // first ERROR cycle is a wait state
      e_resp  = (m_err > 0);
    end
  endtask

  task automatic model_clock();
    int n;
    int k;
    model_expect();
    if (reset) begin
      m_tgt = -1;
      m_err = 0;
      armed = 1;
    end else if (armed) begin
      if (m_err > 0) m_err--;
      if (e_ready) begin
        n = 0;
        k = 0;
        for (int i = 0; i < PC; i++) if (sel[i]) begin n++; k = i; end
        m_tgt = (n == 1) ? k : -1;
        if (m_tgt < 0 && trans >= 2) m_err = 2;
      end
    end
  endtask

  task automatic check_model();
    if (armed && !reset) begin
      model_expect();
      vectors++;
      if (rData !== e_data || ready !== e_ready || resp !== e_resp) begin
        errors++;
        $display("FAIL model t=%0t: rData=%h ready=%b resp=%b, required rData=%h ready=%b resp=%b",
                 $time, rData, ready, resp, e_data, e_ready, e_resp);
      end
    end
  endtask

  task automatic expect_lit(input string name, input logic r, input logic s,
                            input logic [DW-1:0] d);
    #1;
    vectors++;
    if (rData !== d || ready !== r || resp !== s) begin
      errors++;
      $display("FAIL %s: rData=%h ready=%b resp=%b, required rData=%h ready=%b resp=%b",
               name, rData, ready, resp, d, r, s);
    end
  endtask

  // Called right after a negedge with inputs already set.
  task automatic tick();
    #1;
    check_model();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic idle_bus();
    sel   = '0;
    trans = 2'd0;
  endtask

  initial begin
    reset        = 1'b0;
    sel          = '0;
    trans        = 2'd0;
    prphRData    = '0;
    prphReadyOut = '1;
    prphResp     = '0;
    @(negedge clk);

    // Reset for two cycles.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    expect_lit("reset_state", 1'b1, 1'b0, 32'h0);
    tick();

    // Mapped one-cycle read from port 2.
    prphRData[2*DW +: DW] = 32'hCAFE_0002;
    sel = 4'b0100; trans = 2'd2;
    tick();
    idle_bus();
    expect_lit("mapped_read", 1'b1, 1'b0, 32'hCAFE_0002);
    tick();

    // Wait states on port 1 while the decoder already selects port 3.
    prphRData[1*DW +: DW] = 32'h1111_0001;
    prphRData[3*DW +: DW] = 32'h3333_0003;
    sel = 4'b0010; trans = 2'd2;
    tick();
    sel = 4'b1000; trans = 2'd2;
    prphReadyOut[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      expect_lit("wait_hold_p1", 1'b0, 1'b0, 32'h1111_0001);
      tick();
    end
    prphReadyOut[1] = 1'b1;
    expect_lit("wait_last_p1", 1'b1, 1'b0, 32'h1111_0001);
    tick();
    idle_bus();
    expect_lit("after_wait_p3", 1'b1, 1'b0, 32'h3333_0003);
    tick();

    // Unmapped NONSEQ: two-cycle ERROR, then OKAY.
    sel = '0; trans = 2'd2;
    tick();
    idle_bus();
    expect_lit("unmapped_err1", 1'b0, 1'b1, 32'h0);
    tick();
    expect_lit("unmapped_err2", 1'b1, 1'b1, 32'h0);
    tick();
    expect_lit("unmapped_okay", 1'b1, 1'b0, 32'h0);
    tick();

    // Unmapped IDLE is a zero-wait OKAY.
    sel = '0; trans = 2'd0;
    tick();
    expect_lit("unmapped_idle", 1'b1, 1'b0, 32'h0);

    // Multi-hot SEQ is treated as unmapped.
    sel = 4'b0011; trans = 2'd3;
    tick();
    idle_bus();
    expect_lit("multihot_err1", 1'b0, 1'b1, 32'h0);
    tick();
    expect_lit("multihot_err2", 1'b1, 1'b1, 32'h0);
    tick();

    // Back-to-back unmapped NONSEQ.
    sel = '0; trans = 2'd2;
    tick();
    expect_lit("b2b_err1_a", 1'b0, 1'b1, 32'h0);
    tick();
    expect_lit("b2b_err2_a", 1'b1, 1'b1, 32'h0);
    tick();
    idle_bus();
    expect_lit("b2b_err1_b", 1'b0, 1'b1, 32'h0);
    tick();
    expect_lit("b2b_err2_b", 1'b1, 1'b1, 32'h0);
    tick();
    expect_lit("b2b_okay", 1'b1, 1'b0, 32'h0);

    // Reset in the middle of ERR1 aborts the ERROR sequence.
    sel = '0; trans = 2'd2;
    tick();
    idle_bus();
    expect_lit("midreset_err1", 1'b0, 1'b1, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_lit("midreset_ok", 1'b1, 1'b0, 32'h0);
    tick();
    expect_lit("midreset_no_err2", 1'b1, 1'b0, 32'h0);
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind < 6)      sel = PC'(1 << $urandom_range(0, PC-1));
      else if (kind < 8) sel = '0;
      else               sel = PC'($urandom);
      trans = 2'($urandom);
      for (int p = 0; p < PC; p++) prphRData[p*DW +: DW] = $urandom;
      for (int p = 0; p < PC; p++) prphReadyOut[p] = ($urandom_range(0, 9) < 7);
      for (int p = 0; p < PC; p++) prphResp[p] = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 59) == 0);
      tick();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
